prime_pace_buffer: RTL and testbench

PRIME_PACE_BUFFER -- requirements
Module: prime_pace_buffer

---
 rtl/prime_pkg.sv | 13 +
 rtl/prime_fifo.sv | 49 ++++
 rtl/prime_pace_buffer.sv | 90 +++++++++
 tb/tb_prime_pace_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime pacing display path.
package prime_pkg;

    localparam int PRIME_W     = 20;
    localparam int TICK_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        SHOW   = 2'd2
    } pace_state_t;

endpackage

// File: rtl/prime_fifo.sv
// Circular prime buffer: tail write on push, head read on pop, flush empties it.
module prime_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn_signal,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/prime_pace_buffer.sv
// Buffers primes from the sieve and releases one to the display per tick.
// Optional macro PRIME_PACE_STATS_EN adds a saturating shown_cnt output.
module prime_pace_buffer
    import prime_pkg::*;
#(
    parameter int W     = PRIME_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn_signal,
    input  logic                     tick,
    input  logic                     pause,
    input  logic                     clear,
    input  logic                     prime_valid,
    input  logic [W-1:0]             prime_data,
    output logic                     prime_ready,
    output logic [W-1:0]             disp_value,
    output logic                     disp_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef PRIME_PACE_STATS_EN
    ,
    output logic [W-1:0]             shown_cnt
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;

    pace_state_t  state;
    pace_state_t  state_next;
    logic         push;
    logic         pop;
    logic [W-1:0] head;

    // Ready looks only at registered occupancy so it never depends on prime_valid.
    assign prime_ready = (fifo_level != LW'(DEPTH)) && !clear;
    assign push        = prime_valid && prime_ready;
    assign disp_strobe = (state == SHOW);

    prime_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn_signal (rstn_signal),
        .push        (push),
        .pop         (pop),
        .flush       (clear),
        .wdata       (prime_data),
        .rdata       (head),
        .level       (fifo_level)
    );

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) state <= EMPTY;
        else              state <= state_next;
    end

    // A push while EMPTY only arms LOADED, so a same-cycle tick cannot pop it.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            EMPTY:   if (push) state_next = LOADED;
            LOADED:  if (tick && !pause) begin
                         state_next = SHOW;
                         pop        = 1'b1;
                     end
            SHOW:    state_next = ((fifo_level != '0) || push) ? LOADED : EMPTY;
            default: state_next = EMPTY;
        endcase
        if (clear) begin
            state_next = EMPTY;
            pop        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) disp_value <= '0;
        else if (pop)     disp_value <= head;
    end

`ifdef PRIME_PACE_STATS_EN
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal)                       shown_cnt <= '0;
        else if (clear)                         shown_cnt <= '0;
        else if (disp_strobe && shown_cnt != '1) shown_cnt <= shown_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_prime_pace_buffer.sv
// Directed bench for prime_pace_buffer: vector table plus hand-built corner sequences.
module tb_prime_pace_buffer;

    localparam int W     = 20;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rstn_signal;
    logic         tick, pause, clear, prime_valid;
    logic [W-1:0] prime_data;
    logic         prime_ready;
    logic [W-1:0] disp_value;
    logic         disp_strobe;
    logic [3:0]   fifo_level;
`ifdef PRIME_PACE_STATS_EN
    logic [W-1:0] shown_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prime_pace_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn_signal (rstn_signal),
        .tick        (tick),
        .pause       (pause),
        .clear       (clear),
        .prime_valid (prime_valid),
        .prime_data  (prime_data),
        .prime_ready (prime_ready),
        .disp_value  (disp_value),
        .disp_strobe (disp_strobe),
        .fifo_level  (fifo_level)
`ifdef PRIME_PACE_STATS_EN
        ,
        .shown_cnt   (shown_cnt)
`endif
    );

    typedef struct {
        logic         tick;
        logic         pause;
        logic         clear;
        logic         valid;
        logic [W-1:0] data;
        logic         ready;
        int           level;
        int           disp;
        logic         strobe;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic t, input logic v, input int d,
                       input logic r, input int lvl, input int dv, input logic s);
        vecs[nv].tick   = t;
        vecs[nv].pause  = 1'b0;
        vecs[nv].clear  = 1'b0;
        vecs[nv].valid  = v;
        vecs[nv].data   = W'(d);
        vecs[nv].ready  = r;
        vecs[nv].level  = lvl;
        vecs[nv].disp   = dv;
        vecs[nv].strobe = s;
        nv++;
    endtask

    task automatic drive(input logic t, input logic p, input logic c,
                         input logic v, input int d);
        tick        = t;
        pause       = p;
        clear       = c;
        prime_valid = v;
        prime_data  = W'(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic t, input logic p, input logic c,
                       input logic v, input int d);
        drive(t, p, c, v, d);
        step();
        drive(1'b0, p, 1'b0, 1'b0, 0);
    endtask

    task automatic chk_out(input string tag, input int lvl, input int dv, input logic s);
        chk({tag, "_level"},  int'(fifo_level),  lvl);
        chk({tag, "_disp"},   int'(disp_value),  dv);
        chk({tag, "_strobe"}, int'(disp_strobe), int'(s));
    endtask

    initial begin
        int primes[8] = '{2, 3, 5, 7, 11, 13, 17, 19};
        int shown[6]  = '{3, 5, 7, 11, 13, 17};

        // Single value: push 2, tick, then a tick while empty
        add(0, 1, 2, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 2, 1);
        add(0, 0, 0, 1, 0, 2, 0);
        add(1, 0, 0, 1, 0, 2, 0);
        // Fill to DEPTH, then hold 23 against backpressure
        for (int i = 0; i < 8; i++) add(0, 1, primes[i], 1, i + 1, 2, 0);
        add(0, 1, 23, 0, 8, 2, 0);
        add(0, 1, 23, 0, 8, 2, 0);
        add(1, 1, 23, 0, 7, 2, 1);
        add(0, 1, 23, 1, 8, 2, 0);
        for (int i = 0; i < 5; i++) begin
            add(1, 0, 0, i == 0 ? 1'b0 : 1'b1, 7 - i, shown[i], 1);
            add(0, 0, 0, 1, 7 - i, shown[i], 0);
        end
        // Level 3 (17,19,23): push 29 on the tick cycle
        add(1, 1, 29, 1, 3, 17, 1);
        add(0, 0, 0, 1, 3, 17, 0);
        add(1, 0, 0, 1, 2, 19, 1);
        add(0, 0, 0, 1, 2, 19, 0);
        add(1, 0, 0, 1, 1, 23, 1);
        add(0, 0, 0, 1, 1, 23, 0);
        add(1, 0, 0, 1, 0, 29, 1);
        add(0, 0, 0, 1, 0, 29, 0);

        rstn_signal = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_ready", int'(prime_ready), 1);
        chk_out("rst", 0, 0, 0);
        rstn_signal = 1'b1;
        step();

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].tick, vecs[i].pause, vecs[i].clear, vecs[i].valid, int'(vecs[i].data));
            #1;
            chk($sformatf("v%0d_ready", i), int'(prime_ready), int'(vecs[i].ready));
            step();
            chk_out($sformatf("v%0d", i), vecs[i].level, vecs[i].disp, vecs[i].strobe);
        end
        drive(0, 0, 0, 0, 0);

        // Paused ticks are dropped
        cyc(0, 0, 0, 1, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0);
            chk_out($sformatf("pause%0d", i), 1, 29, 0);
            cyc(0, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_out("unpause", 0, 5, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_out("empty_tick", 0, 5, 0);

        // Push into empty with a same-cycle tick is not popped
        cyc(1, 0, 0, 1, 31);
        chk_out("push_tick_empty", 1, 5, 0);
        cyc(1, 0, 0, 0, 0);
        chk_out("next_tick", 0, 31, 1);
        cyc(0, 0, 0, 0, 0);

        // Clear with 4 queued and 7 on display, racing a tick and a push
        cyc(0, 0, 0, 1, 7);
        cyc(1, 0, 0, 0, 0);
        chk_out("show7", 0, 7, 1);
        cyc(0, 0, 0, 1, 41);
        cyc(0, 0, 0, 1, 43);
        cyc(0, 0, 0, 1, 47);
        cyc(0, 0, 0, 1, 53);
        chk("queued4", int'(fifo_level), 4);
        drive(1, 0, 1, 1, 59);
        #1;
        chk("clear_ready", int'(prime_ready), 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk_out("clear", 0, 7, 0);
        cyc(1, 0, 0, 0, 0);
        chk_out("tick_after_clear", 0, 7, 0);

`ifdef PRIME_PACE_STATS_EN
        chk("stats_after_clear", int'(shown_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 61 + i);
            cyc(1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("stats_five", int'(shown_cnt), 5);
        cyc(0, 0, 1, 0, 0);
        chk("stats_clear", int'(shown_cnt), 0);
`endif

        // Asynchronous reset mid-operation
        cyc(0, 0, 0, 1, 67);
        cyc(0, 0, 0, 1, 71);
        cyc(1, 0, 0, 0, 0);
        chk_out("pre_reset", 1, 67, 1);
        cyc(0, 0, 0, 1, 73);
        #2;
        rstn_signal = 1'b0;
        #1;
        chk("midrst_ready", int'(prime_ready), 1);
        chk_out("midrst", 0, 0, 0);
        step();
        step();
        rstn_signal = 1'b1;
        step();
        chk_out("post_release", 0, 0, 0);
        chk("post_release_ready", int'(prime_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
